// File: rtl/pdm_modulator.sv
// pdm_modulator: signed 8-bit PCM to 1-bit PDM via a small sample FIFO and a sigma-delta loop.
// Define PDM_SECOND_ORDER_EN to replace the first-order loop with a second-order error-feedback loop.
module pdm_modulator #(
    parameter int DIV   = 100,
    parameter int OSR   = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [7:0]               s_data,
    output logic                     pdm_out,
    output logic                     bit_strobe,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DIV);
    localparam int BW = $clog2(OSR);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   lvl_q, lvl_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [7:0]    cur_q, x;
    logic          pdm_q, pdm_d, strobe_q, under_q;
    logic          push, tick, boundary, pop;

    assign s_ready    = lvl_q < (AW+1)'(DEPTH);
    assign push       = s_valid && s_ready;
    assign tick       = enable && div_q == DW'(DIV - 1);
    assign boundary   = tick && bit_q == '0;
    assign pop        = boundary && lvl_q != '0;
    assign pdm_out    = pdm_q;
    assign bit_strobe = strobe_q;
    assign underrun   = under_q;
    assign fifo_level = lvl_q;

`ifdef PDM_SECOND_ORDER_EN
    logic signed [11:0] i1_q, i1_d;
    logic signed [13:0] i2_q, i2_d;
    logic signed [15:0] xs, fb, t1, t2;
`else
    logic [7:0] acc_q, acc_d;
    logic [8:0] sum;
`endif

    // Next-state: sample selection, divider/bit counters and the modulator loop
    always_comb begin
        lvl_d = lvl_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        div_d = tick ? '0 : div_q + DW'(1);
        bit_d = tick ? bit_q + BW'(1) : bit_q;
        x     = bit_q != '0 ? cur_q : (pop ? mem_q[rd_q] : 8'd0);
`ifdef PDM_SECOND_ORDER_EN
        xs    = {{8{x[7]}}, x};
        fb    = pdm_q ? 16'sd128 : -16'sd128;
        t1    = {{4{i1_q[11]}}, i1_q} + xs - fb;
        i1_d  = t1 > 16'sd2047 ? 12'sd2047 : (t1 < -16'sd2047 ? -12'sd2047 : t1[11:0]);
        t2    = {{2{i2_q[13]}}, i2_q} + {{4{i1_d[11]}}, i1_d} - fb;
        i2_d  = t2 > 16'sd8191 ? 14'sd8191 : (t2 < -16'sd8191 ? -14'sd8191 : t2[13:0]);
        pdm_d = !i2_d[13];
`else
        sum   = {1'b0, acc_q} + {1'b0, ~x[7], x[6:0]};
        acc_d = sum[7:0];
        pdm_d = sum[8];
`endif
    end

    // FIFO storage; contents need no reset since pointers and level define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= s_data;
    end

    // Pointers, counters and registered outputs; enable low flushes only the datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= '0;
            wr_q     <= '0;
            lvl_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            cur_q    <= '0;
            pdm_q    <= 1'b0;
            strobe_q <= 1'b0;
            under_q  <= 1'b0;
`ifdef PDM_SECOND_ORDER_EN
            i1_q     <= '0;
            i2_q     <= '0;
`else
            acc_q    <= '0;
`endif
        end else begin
            lvl_q <= lvl_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            if (!enable) begin
                div_q    <= '0;
                bit_q    <= '0;
                cur_q    <= '0;
                pdm_q    <= 1'b0;
                strobe_q <= 1'b0;
                under_q  <= 1'b0;
`ifdef PDM_SECOND_ORDER_EN
                i1_q     <= '0;
                i2_q     <= '0;
`else
                acc_q    <= '0;
`endif
            end else begin
                div_q    <= div_d;
                bit_q    <= bit_d;
                strobe_q <= tick;
                under_q  <= boundary && lvl_q == '0;
                if (tick) begin
                    cur_q <= x;
                    pdm_q <= pdm_d;
`ifdef PDM_SECOND_ORDER_EN
                    i1_q  <= i1_d;
                    i2_q  <= i2_d;
`else
                    acc_q <= acc_d;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_pdm_modulator.sv
// tb_pdm_modulator: directed stimulus with a sample-queue reference model checked every cycle.
module tb_pdm_modulator;
    localparam int DIV = 4, OSR = 16, DEPTH = 4;

    logic       clk = 1'b0, rst_n = 1'b1, enable = 1'b0, s_valid = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_ready, pdm_out, bit_strobe, underrun;
    logic [2:0] fifo_level;
    int         errors = 0, checks = 0;

    pdm_modulator #(.DIV(DIV), .OSR(OSR), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .pdm_out(pdm_out), .bit_strobe(bit_strobe), .underrun(underrun),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int l);
        return v > l ? l : (v < -l ? -l : v);
    endfunction

    // Reference model: sample queue, bit-period phase and an integer-valued loop state
    int q[$];
    int m_div, m_bit, m_acc, m_cur, m_i1, m_i2, mx, fb;
    bit m_pdm, m_strobe, m_under, mpush;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_div = 0; m_bit = 0; m_acc = 0; m_cur = 0; m_i1 = 0; m_i2 = 0;
            m_pdm = 0; m_strobe = 0; m_under = 0;
        end else begin
            mpush = s_valid && q.size() < DEPTH;
            m_strobe = 0;
            m_under = 0;
            if (!enable) begin
                m_div = 0; m_bit = 0; m_acc = 0; m_cur = 0; m_i1 = 0; m_i2 = 0; m_pdm = 0;
            end else if (m_div < DIV - 1) begin
                m_div++;
            end else begin
                m_div = 0;
                m_strobe = 1;
                if (m_bit == 0) begin
                    if (q.size() > 0) mx = q.pop_front();
                    else begin mx = 0; m_under = 1; end
                end else mx = m_cur;
                m_cur = mx;
`ifdef PDM_SECOND_ORDER_EN
                fb = m_pdm ? 128 : -128;
                m_i1 = sat(m_i1 + mx - fb, 2047);
                m_i2 = sat(m_i2 + m_i1 - fb, 8191);
                m_pdm = m_i2 >= 0;
`else
                m_acc = m_acc + mx + 128;
                m_pdm = m_acc >= 256;
                m_acc = m_acc % 256;
`endif
                m_bit = (m_bit + 1) % OSR;
            end
            if (mpush) q.push_back(int'($signed(s_data)));
        end
    end

    // Compare every output against the model once per cycle, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pdm_out", pdm_out, m_pdm);
            chk("bit_strobe", bit_strobe, m_strobe);
            chk("underrun", underrun, m_under);
            chk("fifo_level", fifo_level, q.size());
            chk("s_ready", s_ready, q.size() < DEPTH);
        end
    end

    task automatic push1(input logic [7:0] d);
        s_valid = 1'b1;
        s_data = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Observe n strobes: ones, underruns, first bit, latency to first strobe, bad gaps
    task automatic run(input int n, output int ones, output int un, output int first,
                       output int lat, output int gb);
        int cnt = 0, last = 0;
        ones = 0; un = 0; first = -1; lat = -1; gb = 0;
        for (int c = 1; c <= n * DIV + DIV + 8 && cnt < n; c++) begin
            @(negedge clk);
            if (bit_strobe) begin
                if (cnt == 0) begin first = pdm_out; lat = c; end
                else if (c - last != DIV) gb++;
                last = c;
                ones += pdm_out;
                un += underrun;
                cnt++;
            end
        end
        if (cnt < n) chk("strobe_timeout", cnt, n);
    endtask

    initial begin
        int ones, un, first, lat, gb, acc;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pdm", pdm_out, 0);
        chk("rst_strobe", bit_strobe, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_level", fifo_level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        push1(8'h00);
        enable = 1'b1;
        run(16, ones, un, first, lat, gb);
`ifndef PDM_SECOND_ORDER_EN
        chk("zero_ones", ones, 8);
        chk("zero_first", first, 0);
`endif
        chk("zero_under", un, 0);
        chk("enable_latency", lat, DIV);
        chk("strobe_gap", gb, 0);
        enable = 1'b0;
        @(negedge clk);

        push1(8'h7f);
        push1(8'h80);
        enable = 1'b1;
        run(16, ones, un, first, lat, gb);
`ifndef PDM_SECOND_ORDER_EN
        chk("max_ones", ones, 15);
        chk("max_first", first, 0);
`endif
        chk("max_under", un, 0);
        run(16, ones, un, first, lat, gb);
`ifndef PDM_SECOND_ORDER_EN
        chk("min_ones", ones, 0);
`endif
        chk("min_under", un, 0);
        run(1, ones, un, first, lat, gb);
        chk("third_boundary_under", un, 1);
        enable = 1'b0;
        @(negedge clk);

        acc = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 8'(10 + i);
            if (s_ready) acc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("accepted", acc, 4);
        chk("full_ready", s_ready, 0);
        chk("full_level", fifo_level, 4);
        enable = 1'b1;
        run(1, ones, un, first, lat, gb);
        chk("level_after_1", fifo_level, 3);
        run(16, ones, un, first, lat, gb);
        chk("level_after_17", fifo_level, 2);
        run(47, ones, un, first, lat, gb);
        chk("drain_under", un, 0);
        chk("drain_level", fifo_level, 0);
        run(64, ones, un, first, lat, gb);
        chk("empty_under", un, 4);
`ifndef PDM_SECOND_ORDER_EN
        chk("midscale_ones", ones, 32);
`endif
        enable = 1'b0;
        @(negedge clk);

        for (int i = 1; i <= 4; i++) push1(8'(i));
        enable = 1'b1;
        run(1, ones, un, first, lat, gb);
        chk("pre_reset_level", fifo_level, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pdm", pdm_out, 0);
        chk("arst_strobe", bit_strobe, 0);
        chk("arst_under", underrun, 0);
        chk("arst_ready", s_ready, 1);
        chk("arst_level", fifo_level, 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
